lcd_bus_responder: RTL and testbench

//  Receiving end of the 4-bit character-LCD bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW) that lcd_ctrl drives.

---
 rtl/lcd_resp_pkg.sv | 24 ++
 rtl/lcd_e_sync.sv | 68 ++++++
 rtl/lcd_bus_responder.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_resp_pkg.sv
// Shared definitions for the character-LCD bus responder.
//  - resp_state_e : 4-bit-mode FSM state encoding
//  - ADDR_W/BUF_DEPTH : DDRAM address width and mirrored buffer depth (2x16)
//  - CMD_* : HD44780 command masks/opcodes recognised by the responder
package lcd_resp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HIGH_PEND = 2'd1,
        CLEARING  = 2'd2
    } resp_state_e;

    localparam int ADDR_W    = 5;
    localparam int BUF_DEPTH = 32;

    localparam logic [7:0] CMD_SET_DD_MASK = 8'h80;
    localparam logic [7:0] CMD_SET_DD      = 8'h80;
    localparam logic [7:0] CMD_ENTRY_MASK  = 8'hFC;
    localparam logic [7:0] CMD_ENTRY       = 8'h04;
    localparam logic [7:0] CMD_HOME_MASK   = 8'hFE;
    localparam logic [7:0] CMD_HOME        = 8'h02;
    localparam logic [7:0] CMD_CLR         = 8'h01;

endpackage

// File: rtl/lcd_e_sync.sv
// LCD_E synchronizer and strobe qualifier.
//  clk, reset      : system clock, async active-low reset
//  e_raw           : raw LCD_E (asynchronous)
//  d_raw/rs_raw/rw_raw : raw bus fields, captured every cycle while synced E is high
//  strobe          : one-cycle pulse, E fell after a high time >= MIN_E_CYCLES
//  glitch          : one-cycle pulse, E fell after a shorter high time
//  cap_d/cap_rs/cap_rw : bus values captured during the last synced-high cycle
module lcd_e_sync #(
    parameter int MIN_E_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_raw,
    input  logic [3:0] d_raw,
    input  logic       rs_raw,
    input  logic       rw_raw,
    output logic       strobe,
    output logic       glitch,
    output logic [3:0] cap_d,
    output logic       cap_rs,
    output logic       cap_rw
);

    localparam int CW = $clog2(MIN_E_CYCLES + 1);
    localparam logic [CW-1:0] HI_LOAD = CW'(MIN_E_CYCLES);
    localparam logic [CW-1:0] HI_ONE  = CW'(1);

    logic          e_s1;
    logic          e_s2;
    logic          e_s2_d;
    logic [CW-1:0] hi_cnt;
    logic          e_fall;

    assign e_fall = e_s2_d & ~e_s2;

    // hi_cnt is reloaded while E is low and counts down during the high
    // phase; reaching zero by the falling edge means the pulse was long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_s1   <= 1'b0;
            e_s2   <= 1'b0;
            e_s2_d <= 1'b0;
            hi_cnt <= HI_LOAD;
            strobe <= 1'b0;
            glitch <= 1'b0;
            cap_d  <= 4'h0;
            cap_rs <= 1'b0;
            cap_rw <= 1'b0;
        end else begin
            e_s1   <= e_raw;
            e_s2   <= e_s1;
            e_s2_d <= e_s2;
            if (!e_s2) begin
                hi_cnt <= HI_LOAD;
            end else if (hi_cnt != '0) begin
                hi_cnt <= hi_cnt - HI_ONE;
            end
            if (e_s2) begin
                cap_d  <= d_raw;
                cap_rs <= rs_raw;
                cap_rw <= rw_raw;
            end
            strobe <= e_fall && (hi_cnt == '0);
            glitch <= e_fall && (hi_cnt != '0);
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// Minimal HD44780 responder for the 4-bit character-LCD bus.
// Reassembles nibbles into bytes, executes the address-related commands,
// and mirrors the 2x16 DDRAM into a 32-byte character buffer.
//  clk, reset            : system clock, async active-low reset
//  SF_D, LCD_E, LCD_RS, LCD_RW : LCD bus as driven by the controller
//  rd_addr / rd_char     : combinational buffer read port
//  byte_valid/byte_rs/byte_data : one-cycle report of each received byte
//  addr_ctr              : DDRAM address counter
//  nib_mode              : 4-bit interface mode active
//  busy                  : clear in progress
//  err                   : sticky protocol error
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | waiting for a strobe (full byte in 8-bit mode, high nibble in 4-bit)
//  HIGH_PEND | high nibble latched, waiting for the low nibble
//  CLEARING  | writing BLANK_CHAR to one buffer location per cycle
module lcd_bus_responder
    import lcd_resp_pkg::*;
#(
    parameter int         MIN_E_CYCLES = 2,
    parameter logic [7:0] BLANK_CHAR   = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        SF_D,
    input  logic              LCD_E,
    input  logic              LCD_RS,
    input  logic              LCD_RW,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic              byte_valid,
    output logic              byte_rs,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] addr_ctr,
    output logic              nib_mode,
    output logic              busy,
    output logic              err
);

    logic       strobe;
    logic       glitch;
    logic [3:0] cap_d;
    logic       cap_rs;
    logic       cap_rw;

    lcd_e_sync #(
        .MIN_E_CYCLES (MIN_E_CYCLES)
    ) u_e_sync (
        .clk    (clk),
        .reset  (reset),
        .e_raw  (LCD_E),
        .d_raw  (SF_D),
        .rs_raw (LCD_RS),
        .rw_raw (LCD_RW),
        .strobe (strobe),
        .glitch (glitch),
        .cap_d  (cap_d),
        .cap_rs (cap_rs),
        .cap_rw (cap_rw)
    );

    resp_state_e       state, state_nx;
    logic              nib_mode_nx;
    logic [3:0]        hi_nib, hi_nib_nx;
    logic              hi_rs, hi_rs_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              incr, incr_nx;
    logic              err_nx;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              bv_nx;
    logic              brs_nx;
    logic [7:0]        bdata_nx;
    logic [7:0]        full_byte;

    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [7:0]        buf_wdata;
    logic [7:0]        char_buf [BUF_DEPTH];

    assign full_byte = {hi_nib, cap_d};
    assign busy      = (state == CLEARING);
    assign rd_char   = char_buf[rd_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            nib_mode   <= 1'b0;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            addr_ctr   <= '0;
            incr       <= 1'b1;
            err        <= 1'b0;
            clr_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            state      <= state_nx;
            nib_mode   <= nib_mode_nx;
            hi_nib     <= hi_nib_nx;
            hi_rs      <= hi_rs_nx;
            addr_ctr   <= addr_nx;
            incr       <= incr_nx;
            err        <= err_nx;
            clr_cnt    <= clr_cnt_nx;
            byte_valid <= bv_nx;
            byte_rs    <= brs_nx;
            byte_data  <= bdata_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        nib_mode_nx = nib_mode;
        hi_nib_nx   = hi_nib;
        hi_rs_nx    = hi_rs;
        addr_nx     = addr_ctr;
        incr_nx     = incr;
        err_nx      = err | glitch;
        clr_cnt_nx  = clr_cnt;
        bv_nx       = 1'b0;
        brs_nx      = byte_rs;
        bdata_nx    = byte_data;
        buf_we      = 1'b0;
        buf_waddr   = addr_ctr;
        buf_wdata   = BLANK_CHAR;

        case (state)
            CLEARING: begin
                buf_we    = 1'b1;
                buf_waddr = clr_cnt;
                if (strobe) begin
                    err_nx = 1'b1;
                end
                if (clr_cnt == '0) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                    incr_nx  = 1'b1;
                end else begin
                    clr_cnt_nx = clr_cnt - 5'd1;
                end
            end
            default: begin
                if (strobe) begin
                    if (cap_rw) begin
                        err_nx = 1'b1;
                    end else if (!nib_mode) begin
                        // 8-bit mode: only the upper data lines are wired, so
                        // every strobe is a whole byte with a zero low nibble.
                        bv_nx    = 1'b1;
                        brs_nx   = cap_rs;
                        bdata_nx = {cap_d, 4'h0};
                        if (cap_d == 4'h2 && !cap_rs) begin
                            nib_mode_nx = 1'b1;
                        end
                    end else if (state == IDLE) begin
                        hi_nib_nx = cap_d;
                        hi_rs_nx  = cap_rs;
                        state_nx  = HIGH_PEND;
                    end else if (cap_rs != hi_rs) begin
                        // Resynchronise on the new nibble rather than pairing
                        // halves of two different transfers.
                        err_nx    = 1'b1;
                        hi_nib_nx = cap_d;
                        hi_rs_nx  = cap_rs;
                    end else begin
                        state_nx = IDLE;
                        bv_nx    = 1'b1;
                        brs_nx   = cap_rs;
                        bdata_nx = full_byte;
                        if (cap_rs) begin
                            buf_we    = 1'b1;
                            buf_wdata = full_byte;
                            addr_nx   = incr ? addr_ctr + 5'd1 : addr_ctr - 5'd1;
                        end else if ((full_byte & CMD_SET_DD_MASK) == CMD_SET_DD) begin
                            addr_nx = {full_byte[6], full_byte[3:0]};
                        end else if ((full_byte & CMD_ENTRY_MASK) == CMD_ENTRY) begin
                            incr_nx = full_byte[1];
                        end else if ((full_byte & CMD_HOME_MASK) == CMD_HOME) begin
                            addr_nx = '0;
                        end else if (full_byte == CMD_CLR) begin
                            state_nx   = CLEARING;
                            clr_cnt_nx = 5'(BUF_DEPTH - 1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                char_buf[i] <= BLANK_CHAR;
            end
        end else if (buf_we) begin
            char_buf[buf_waddr] <= buf_wdata;
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sf_d = 4'h0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic [4:0] addr_ctr;
    logic       nib_mode;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];

    lcd_bus_responder #(
        .MIN_E_CYCLES (2),
        .BLANK_CHAR   (8'h20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SF_D       (sf_d),
        .LCD_E      (lcd_e),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .byte_valid (byte_valid),
        .byte_rs    (byte_rs),
        .byte_data  (byte_data),
        .addr_ctr   (addr_ctr),
        .nib_mode   (nib_mode),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every reported byte must match the oldest expected one.
    always @(negedge clk) begin
        if (reset && byte_valid) begin
            logic [8:0] exp_b;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: got rs=%0b data=%02h, none expected", byte_rs, byte_data);
            end else begin
                exp_b = exp_q.pop_front();
                if ({byte_rs, byte_data} !== exp_b) begin
                    n_fail++;
                    $display("FAIL byte_value: got rs=%0b data=%02h, want rs=%0b data=%02h",
                             byte_rs, byte_data, exp_b[8], exp_b[7:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_nib(input logic [3:0] d, input logic rs, input logic rw, input int hi_cyc);
        @(negedge clk);
        sf_d   = d;
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_e  = 1'b1;
        repeat (hi_cyc) @(negedge clk);
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        exp_q.push_back({rs, b});
        send_nib(b[7:4], rs, 1'b0, 4);
        send_nib(b[3:0], rs, 1'b0, 4);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({byte_valid, byte_rs, byte_data, addr_ctr, nib_mode, busy, err} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bv=%0b rs=%0b data=%02h addr=%0d nib=%0b busy=%0b err=%0b, want all 0",
                     byte_valid, byte_rs, byte_data, addr_ctr, nib_mode, busy, err);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic go_4bit();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, (i == 3) ? 8'h20 : 8'h30});
            send_nib((i == 3) ? 4'h2 : 4'h3, 1'b0, 1'b0, 4);
        end
    endtask

    task automatic check_char(input logic [4:0] a, input logic [7:0] want, input string name);
        rd_addr = a;
        #1;
        n_checks++;
        if (rd_char !== want) begin
            n_fail++;
            $display("FAIL %s: buffer[%0d] got %02h want %02h", name, a, rd_char, want);
        end
    endtask

    task automatic check_addr(input logic [4:0] want, input string name);
        n_checks++;
        if (addr_ctr !== want) begin
            n_fail++;
            $display("FAIL %s: addr_ctr got %0d want %0d", name, addr_ctr, want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            check_char(5'(i), 8'h20, "reset_blank");
        end
    endtask

    task automatic test_init_8bit();
        int lat;
        // First nibble driven by hand to measure fall-to-byte_valid latency.
        exp_q.push_back({1'b0, 8'h30});
        @(negedge clk);
        sf_d = 4'h3; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (byte_valid) break;
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL latency: byte_valid after %0d clk, want 4", lat);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 8'h30});
            send_nib(4'h3, 1'b0, 1'b0, 4);
        end
        n_checks++;
        if (nib_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL nib_mode_early: got %0b want 0", nib_mode);
        end
        exp_q.push_back({1'b0, 8'h20});
        send_nib(4'h2, 1'b0, 1'b0, 4);
        n_checks++;
        if (nib_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL nib_mode_set: got %0b want 1", nib_mode);
        end
    endtask

    task automatic test_data_write();
        send_byte(8'h48, 1'b1);
        send_byte(8'h69, 1'b1);
        check_char(5'd0, 8'h48, "data_0");
        check_char(5'd1, 8'h69, "data_1");
        check_addr(5'd2, "data_addr");
    endtask

    task automatic test_addressing();
        send_byte(8'hC5, 1'b0);
        check_addr(5'd21, "setdd_c5");
        send_byte(8'h41, 1'b1);
        check_char(5'd21, 8'h41, "row1_write");
        check_addr(5'd22, "row1_addr");
        send_byte(8'hCF, 1'b0);
        check_addr(5'd31, "setdd_cf");
        send_byte(8'h42, 1'b1);
        check_char(5'd31, 8'h42, "write_31");
        check_addr(5'd0, "wrap_up");
        send_byte(8'h43, 1'b1);
        check_char(5'd0, 8'h43, "write_0_after_wrap");
        check_addr(5'd1, "after_wrap");
        send_byte(8'h04, 1'b0);
        send_byte(8'h80, 1'b0);
        check_addr(5'd0, "setdd_80");
        send_byte(8'h44, 1'b1);
        check_char(5'd0, 8'h44, "dec_write");
        check_addr(5'd31, "wrap_down");
        send_byte(8'h02, 1'b0);
        check_addr(5'd0, "home");
        // Leave decrement mode active; the clear must restore increment.
    endtask

    task automatic test_clear();
        int waited;
        int busy_cnt;
        int guard;
        exp_q.push_back({1'b0, 8'h01});
        send_nib(4'h0, 1'b0, 1'b0, 4);
        @(negedge clk);
        sf_d = 4'h1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        waited = 0;
        while (!busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_busy_start: busy got %0b want 1", busy);
        end
        busy_cnt = 0;
        guard = 0;
        while (busy && guard < 100) begin
            busy_cnt++;
            if (guard == 2) begin
                sf_d = 4'h7; lcd_rs = 1'b1; lcd_e = 1'b1;
            end
            if (guard == 6) lcd_e = 1'b0;
            @(negedge clk);
            guard++;
        end
        lcd_e = 1'b0;
        n_checks++;
        if (busy_cnt !== 32) begin
            n_fail++;
            $display("FAIL clear_busy_len: busy for %0d cycles want 32", busy_cnt);
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_strobe_err: err got %0b want 1", err);
        end
        check_addr(5'd0, "clear_addr");
        for (int i = 0; i < 32; i++) begin
            check_char(5'(i), 8'h20, "clear_blank");
        end
        send_byte(8'h5A, 1'b1);
        check_char(5'd0, 8'h5A, "post_clear_write");
        check_addr(5'd1, "post_clear_incr");
    endtask

    task automatic test_errors();
        // Short E pulse.
        go_4bit();
        send_nib(4'h4, 1'b1, 1'b0, 1);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_err: err got %0b want 1", err);
        end
        check_char(5'd0, 8'h20, "glitch_buf");
        send_byte(8'h33, 1'b1);
        check_char(5'd0, 8'h33, "glitch_fsm_idle");

        // Read strobe.
        go_4bit();
        send_nib(4'h6, 1'b1, 1'b1, 4);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_err: err got %0b want 1", err);
        end
        check_char(5'd0, 8'h20, "rw_buf");
        send_byte(8'h55, 1'b1);
        check_char(5'd0, 8'h55, "rw_fsm_idle");

        // RS flips between nibbles: the second nibble becomes a new high nibble.
        go_4bit();
        send_nib(4'h4, 1'b1, 1'b0, 4);
        send_nib(4'h8, 1'b0, 1'b0, 4);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL rsflip_err: err got %0b want 1", err);
        end
        check_char(5'd0, 8'h20, "rsflip_buf");
        exp_q.push_back({1'b0, 8'h81});
        send_nib(4'h1, 1'b0, 1'b0, 4);
        check_addr(5'd1, "rsflip_new_high");
        check_char(5'd0, 8'h20, "rsflip_buf_after");
    endtask

    task automatic test_reset_midway();
        int waited;
        // Reset while a high nibble is pending.
        go_4bit();
        send_byte(8'h61, 1'b1);
        send_nib(4'h7, 1'b1, 1'b0, 4);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({byte_valid, addr_ctr, nib_mode, busy, err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_highpend: addr=%0d nib=%0b busy=%0b err=%0b, want 0",
                     addr_ctr, nib_mode, busy, err);
        end
        check_char(5'd0, 8'h20, "reset_highpend_buf");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        go_4bit();
        send_byte(8'h62, 1'b1);
        check_char(5'd0, 8'h62, "partial_nibble_lost");

        // Reset in the middle of a clear.
        send_byte(8'h01, 1'b0);
        waited = 0;
        while (!busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({byte_valid, addr_ctr, nib_mode, busy, err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_clearing: addr=%0d nib=%0b busy=%0b err=%0b, want 0",
                     addr_ctr, nib_mode, busy, err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_init_8bit();
        test_data_write();
        test_addressing();
        test_clear();
        test_errors();
        test_reset_midway();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bytes_missing: %0d expected bytes never seen, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
